// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU operation dispatcher and its functional
//   units: the dispatcher FSM state encoding, the unit index assigned to
//   each operation, and default widths.
package alu_pkg;

    // Dispatcher handshake states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_CLR,
        ST_REPORT
    } state_t;

    // Unit index (opcode) of each functional unit
    localparam logic [1:0] OP_COMPLEMENTO = 2'd0;
    localparam logic [1:0] OP_SUMA        = 2'd1;
    localparam logic [1:0] OP_SHIFT       = 2'd2;
    localparam logic [1:0] OP_AND         = 2'd3;

    // Default widths and limits
    localparam int DEFAULT_INPUTSIZE = 8;
    localparam int DEFAULT_NUM_UNITS = 4;
    localparam int DEFAULT_TIMEOUT   = 15;
    localparam int TIMER_W           = 8;

endpackage

// File: rtl/alu_dispatch_timer.sv
// dispatch_timer
//   Loadable down-counter used to bound the dispatcher's wait states.
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     clear       - reload the counter with load_value (has priority)
//     load_value  - number of counted cycles minus one
//     enable      - count down this cycle (stops at zero)
//     expired     - counting and the count has reached zero
module dispatch_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Reload on clear, otherwise decrement while enabled and not yet at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Loading TIMEOUT-1 makes this fire in the TIMEOUT-th counted cycle
    assign expired = enable && (count == '0);

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch
//   Initiator side of the ALU enable/done operation handshake. Accepts one
//   request at a time, raises the selected unit's enable, waits for its
//   done, captures its result, drops enable, waits for done to clear and
//   then pulses valid.
//
//   Optional feature: define ALU_DISPATCH_TIMEOUT_EN to bound both wait
//   states to TIMEOUT cycles each (error pulse and return to IDLE on expiry).
//   Without it the wait states wait indefinitely.
//
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     start      - request strobe (only looked at in IDLE)
//     opcode     - unit index of the request
//     data       - operand of the request
//     busy       - dispatcher not in IDLE
//     enable     - one-hot enable to the units
//     unit_data  - latched operand broadcast to all units
//     done_in    - per-unit done
//     result_in  - per-unit results, unit k in [k*INPUTSIZE +: INPUTSIZE]
//     result     - last captured result
//     valid      - one-cycle completion pulse
//     error      - one-cycle illegal-opcode / timeout pulse
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int INPUTSIZE = DEFAULT_INPUTSIZE,
    parameter int NUM_UNITS = DEFAULT_NUM_UNITS,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    localparam int OPW      = $clog2(NUM_UNITS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [OPW-1:0]                 opcode,
    input  logic [INPUTSIZE-1:0]           data,
    output logic                           busy,
    output logic [NUM_UNITS-1:0]           enable,
    output logic [INPUTSIZE-1:0]           unit_data,
    input  logic [NUM_UNITS-1:0]           done_in,
    input  logic [NUM_UNITS*INPUTSIZE-1:0] result_in,
    output logic [INPUTSIZE-1:0]           result,
    output logic                           valid,
    output logic                           error
);

    if (NUM_UNITS < 2 || NUM_UNITS > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("alu_dispatch: NUM_UNITS or TIMEOUT out of range");
    end

    state_t                 state, state_next;
    logic [OPW-1:0]         sel, sel_next;
    logic [INPUTSIZE-1:0]   unit_data_next;
    logic [INPUTSIZE-1:0]   result_next;
    logic                   error_next;
    logic [NUM_UNITS-1:0]   done_q;
    logic                   sel_done;
    logic                   timeout_hit;

    // All handshake decisions look at the registered done of the selected unit
    assign sel_done = done_q[sel];

`ifdef ALU_DISPATCH_TIMEOUT_EN
    logic timer_clear;
    logic timer_count;

    // Reload on ISSUE and again when moving from WAIT_DONE to WAIT_CLR so
    // each wait state gets its own full budget
    assign timer_clear = (state == ST_ISSUE) || ((state == ST_WAIT_DONE) && sel_done);
    assign timer_count = (state == ST_WAIT_DONE) || (state == ST_WAIT_CLR);

    dispatch_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .load_value (TIMER_W'(TIMEOUT - 1)),
        .enable     (timer_count),
        .expired    (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic and next values of the latched operand, selected unit,
    // captured result and error pulse
    always_comb begin
        state_next     = state;
        sel_next       = sel;
        unit_data_next = unit_data;
        result_next    = result;
        error_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (int'(opcode) < NUM_UNITS) begin
                        sel_next       = opcode;
                        unit_data_next = data;
                        state_next     = ST_ISSUE;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving in the expiry cycle still wins
                if (sel_done) begin
                    result_next = result_in[int'(sel)*INPUTSIZE +: INPUTSIZE];
                    state_next  = ST_WAIT_CLR;
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_CLR: begin
                if (!sel_done) begin
                    state_next = ST_REPORT;
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_REPORT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= '0;
            unit_data <= '0;
            result    <= '0;
            error     <= 1'b0;
            done_q    <= '0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            unit_data <= unit_data_next;
            result    <= result_next;
            error     <= error_next;
            done_q    <= done_in;
        end
    end

    // Enable is decoded from WAIT_DONE and also gated by rst so a reset
    // mid-handshake releases the unit without waiting for the edge
    assign enable = ((state == ST_WAIT_DONE) && !rst) ? (NUM_UNITS'(1) << sel) : '0;
    assign busy   = (state != ST_IDLE);
    assign valid  = (state == ST_REPORT);

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch
//   Randomized self-checking bench for alu_dispatch (INPUTSIZE=8,
//   NUM_UNITS=3, TIMEOUT=4). A behavioural unit model answers the
//   handshake with a programmable done delay/hold; expected timing and
//   results come from the handshake rules applied with plain arithmetic.
module tb_alu_dispatch;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int NU = 3;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      opcode;
    logic [W-1:0]    data;
    logic            busy;
    logic [NU-1:0]   enable;
    logic [W-1:0]    unit_data;
    logic [NU-1:0]   done_in;
    logic [NU*W-1:0] result_in;
    logic [W-1:0]    result;
    logic            valid;
    logic            error;

    int errors = 0;
    int checks = 0;

    // Unit model controls: which unit answers, and how
    int tsel  = 0;
    int tdly  = 1000;
    int thold = 1;

    logic [W-1:0] lastResult = '0;

    always #5 clk = ~clk;

    alu_dispatch #(
        .INPUTSIZE (W),
        .NUM_UNITS (NU),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .data      (data),
        .busy      (busy),
        .enable    (enable),
        .unit_data (unit_data),
        .done_in   (done_in),
        .result_in (result_in),
        .result    (result),
        .valid     (valid),
        .error     (error)
    );

    // What each functional unit computes from its operand
    function automatic logic [W-1:0] unitResult(input int k, input logic [W-1:0] d);
        case (k)
            0:       return ~d;
            1:       return d + 8'h11;
            default: return {d[W-2:0], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] ctl(input logic b, input logic [NU-1:0] en,
                                        input logic v, input logic e);
        return 32'({b, en, v, e});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unit model: done rises tdly cycles after enable rises and stays high
    // thold cycles; the result is garbage until done, then held. Unselected
    // units toggle done and results randomly.
    initial begin : responder
        int           t;
        logic         enPrev;
        logic         active;
        logic [W-1:0] held;
        t = 0; enPrev = 1'b0; active = 1'b0; held = '0;
        done_in = '0; result_in = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NU; k++) begin
                if (k != tsel) begin
                    done_in[k] = 1'($urandom_range(0, 1));
                    result_in[k*W +: W] = W'($urandom);
                end
            end
            if (rst) begin
                active = 1'b0;
            end else if (enable[tsel] && !enPrev) begin
                t = 0;
                active = 1'b1;
                held = unitResult(tsel, unit_data) ^ W'($urandom_range(1, 255));
            end else begin
                t++;
            end
            enPrev = enable[tsel];
            if (active && t == tdly) held = unitResult(tsel, unit_data);
            done_in[tsel] = active && (t >= tdly) && (t < tdly + thold);
            if (active && t >= tdly + thold) active = 1'b0;
            result_in[tsel*W +: W] = held;
        end
    end

    // One full transaction: start in cycle 0, check every cycle up to two
    // cycles after valid. injAt>0 pulses a second start with injOp in that
    // cycle, which must be ignored.
    task automatic applyStimulus(input int op, input logic [W-1:0] dat, input int d,
                                 input int h, input int injAt, input int injOp);
        int r;
        int lastEn;
        logic [W-1:0] expRes;
        tsel = op; tdly = d; thold = h;
        // Valid one cycle after the later of: entering WAIT_CLR, done_q clearing
        r      = ((4 + d > 3 + d + h) ? 4 + d : 3 + d + h) + 1;
        lastEn = 3 + d;
        expRes = unitResult(op, dat);
        @(negedge clk);
        start = 1'b1; opcode = 2'(op); data = dat;
        for (int c = 1; c <= r + 2; c++) begin
            @(negedge clk);
            start = 1'b0; opcode = 2'($urandom); data = W'($urandom);
            if (c == injAt) begin
                start = 1'b1; opcode = 2'(injOp);
            end
            checkOutput($sformatf("txn op%0d d%0d h%0d cyc%0d", op, d, h, c),
                        ctl(busy, enable, valid, error),
                        ctl(c <= r, (c >= 2 && c <= lastEn) ? NU'(1 << op) : '0, c == r, 1'b0));
            if (c == r) begin
                checkOutput($sformatf("result op%0d", op), 32'(result), 32'(expRes));
                checkOutput($sformatf("unit_data op%0d", op), 32'(unit_data), 32'(dat));
            end
        end
        start = 1'b0;
        lastResult = expRes;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; data = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset ctl", ctl(busy, enable, valid, error), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset unit_data", 32'(unit_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Baseline complement unit, valid in cycle 6
        applyStimulus(int'(OP_COMPLEMENTO), 8'hA5, 1, 1, 0, 0);
        // Unit 2 five cycles late
        applyStimulus(int'(OP_SHIFT), 8'h3C, 6, 1, 0, 0);
        // Second start during WAIT_CLR with another opcode
        applyStimulus(int'(OP_SUMA), 8'h70, 1, 4, 6, int'(OP_COMPLEMENTO));

        // Illegal opcode on a three-unit build
        @(negedge clk);
        start = 1'b1; opcode = OP_AND; data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        checkOutput("illegal cyc1", ctl(busy, enable, valid, error), ctl(1'b0, '0, 1'b0, 1'b1));
        checkOutput("illegal result held", 32'(result), 32'(lastResult));
        @(negedge clk);
        checkOutput("illegal cyc2", ctl(busy, enable, valid, error), 32'd0);

        // Reset while in WAIT_DONE
        tsel = 1; tdly = 1000; thold = 1;
        @(negedge clk);
        start = 1'b1; opcode = OP_SUMA; data = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre-reset WAIT_DONE", ctl(busy, enable, valid, error), ctl(1'b1, 3'b010, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset ctl", ctl(busy, enable, valid, error), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("after reset cyc%0d", c), ctl(busy, enable, valid, error), 32'd0);
        end
        lastResult = '0;
        applyStimulus(int'(OP_SUMA), 8'h21, 2, 2, 0, 0);

        // Unit that never answers
        tsel = 2; tdly = 1000; thold = 1;
        @(negedge clk);
        start = 1'b1; opcode = OP_SHIFT; data = 8'h55;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("timeout cyc%0d", c), ctl(busy, enable, valid, error),
                        ctl(c <= TO + 1, (c >= 2 && c <= TO + 1) ? 3'b100 : 3'b000, 1'b0, c == TO + 2));
        end
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("no-timeout cyc%0d", c), ctl(busy, enable, valid, error),
                        ctl(1'b1, (c >= 2) ? 3'b100 : 3'b000, 1'b0, 1'b0));
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("recovered idle", ctl(busy, enable, valid, error), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            int op;
            op = $urandom_range(0, NU - 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(op, W'($urandom), $urandom_range(1, 6), $urandom_range(1, 5),
                          $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
